// File: rtl/mem_arbiter.sv
// Two-master to one-slave memory arbiter: load/store port (m1) normally wins,
// instruction fetch (m0) is promoted after STARVE_MAX consecutive m1 grants.
module mem_arbiter #(
    parameter int TIMEOUT    = 15,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    // master 0: instruction fetch
    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    output logic [31:0] m0_rdata_o,
    output logic        m0_ack_o,
    // master 1: load/store
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic [3:0]  m1_wstrb_i,
    output logic [31:0] m1_rdata_o,
    output logic        m1_ack_o,
    // slave
    output logic        s_req_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    output logic [3:0]  s_wstrb_o,
    input  logic [31:0] s_rdata_i,
    input  logic        s_ack_i,
    // status
    output logic        hold_flag_o,
    output logic        err_o
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state;
    logic          owner;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          grant_m0;

    assign grant_m0    = m0_req_i && (!m1_req_i || starve_cnt == STARVE_TOP);
    assign hold_flag_o = m0_req_i && !m0_ack_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            s_req_o    <= 1'b0;
            s_we_o     <= 1'b0;
            s_addr_o   <= '0;
            s_wdata_o  <= '0;
            s_wstrb_o  <= '0;
            m0_ack_o   <= 1'b0;
            m1_ack_o   <= 1'b0;
            m0_rdata_o <= '0;
            m1_rdata_o <= '0;
            err_o      <= 1'b0;
        end else begin
            // acks and err are single-cycle pulses that only live in RESP
            m0_ack_o <= 1'b0;
            m1_ack_o <= 1'b0;
            err_o    <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req_i || m1_req_i) begin
                        state   <= BUSY;
                        s_req_o <= 1'b1;
                        tmo_cnt <= '0;
                        if (grant_m0) begin
                            owner      <= 1'b0;
                            s_we_o     <= 1'b0;
                            s_addr_o   <= m0_addr_i;
                            s_wdata_o  <= '0;
                            s_wstrb_o  <= 4'h0;
                            starve_cnt <= '0;
                        end else begin
                            owner     <= 1'b1;
                            s_we_o    <= m1_we_i;
                            s_addr_o  <= m1_addr_i;
                            s_wdata_o <= m1_wdata_i;
                            s_wstrb_o <= m1_wstrb_i;
                            if (!m0_req_i)
                                starve_cnt <= '0;
                            else if (starve_cnt != STARVE_TOP)
                                starve_cnt <= starve_cnt + SW'(1);
                        end
                    end
                end
                BUSY: begin
                    // ack is checked first so it wins over a coincident timeout
                    if (s_ack_i) begin
                        state   <= RESP;
                        s_req_o <= 1'b0;
                        if (owner) begin
                            m1_ack_o   <= 1'b1;
                            m1_rdata_o <= s_rdata_i;
                        end else begin
                            m0_ack_o   <= 1'b1;
                            m0_rdata_o <= s_rdata_i;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        state   <= RESP;
                        s_req_o <= 1'b0;
                        err_o   <= 1'b1;
                        if (owner) begin
                            m1_ack_o   <= 1'b1;
                            m1_rdata_o <= '0;
                        end else begin
                            m0_ack_o   <= 1'b1;
                            m0_rdata_o <= '0;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-low reset: clk input 1, rising-edge system clock; rst input 1, asynchronous active-low reset.
REQ-002 The module SHALL have parameter TIMEOUT, default 15: maximum number of BUSY cycles waited for s_ack_i.
REQ-003 The module SHALL have parameter STARVE_MAX, default 4: maximum consecutive m1 grants allowed while m0 is pending.
REQ-004 The module SHALL have these ports on master 0 (instruction fetch): m0_req_i in 1; m0_addr_i in 32; m0_rdata_o out 32; m0_ack_o out 1.
REQ-005 The module SHALL have these ports on master 1 (load/store): m1_req_i in 1; m1_we_i in 1; m1_addr_i in 32; m1_wdata_i in 32; m1_wstrb_i in 4; m1_rdata_o out 32; m1_ack_o out 1.
REQ-006 The module SHALL have these ports on the slave side: s_req_o out 1; s_we_o out 1; s_addr_o out 32; s_wdata_o out 32; s_wstrb_o out 4; s_rdata_i in 32; s_ack_i in 1.
REQ-007 The module SHALL have these status ports: hold_flag_o out 1, pipeline hold toward ctrl; err_o out 1, timeout pulse.

Function
REQ-008 Masters SHALL hold req and address/data stable until their ack; the arbiter SHALL treat any req change before ack as illegal, with undefined behaviour.
REQ-009 The FSM SHALL have states IDLE, BUSY and RESP, plus an owner register (0/1).
REQ-010 In IDLE with any req high, the FSM SHALL register the winner's command into s_* at the next edge, set owner, and enter BUSY.
REQ-011 Priority SHALL be: m1 over m0, except m0 wins when both request and starve_cnt == STARVE_MAX.
REQ-012 starve_cnt SHALL increment on an m1 grant with m0_req_i high, and clear on an m0 grant or on an m1 grant with m0_req_i low.
REQ-013 starve_cnt SHALL saturate at STARVE_MAX.
REQ-014 For an m0 grant, s_we_o SHALL be 0 and s_wstrb_o SHALL be 4'h0.
REQ-015 In BUSY, s_req_o SHALL be 1; s_* SHALL hold constant.
REQ-016 On the edge sampling s_ack_i=1 in BUSY, the arbiter SHALL latch s_rdata_i, drop s_req_o and enter RESP.
REQ-017 If BUSY has lasted TIMEOUT cycles without s_ack_i, the arbiter SHALL drop s_req_o, latch rdata = 0, set err_o and enter RESP.
REQ-018 If s_ack_i and the timeout coincide in the same cycle, the ack SHALL win and err_o SHALL stay 0.
REQ-019 In RESP (exactly 1 cycle), the owner's mX_ack_o SHALL be 1 and mX_rdata_o SHALL carry the latched data; err_o SHALL be valid in this cycle only. The next state SHALL be IDLE.
REQ-020 No grant SHALL occur in RESP, so the acked master's still-high req is never re-granted.
REQ-021 Outside RESP, both mX_ack_o SHALL be 0; mX_rdata_o SHALL hold its last value.
REQ-022 s_ack_i in IDLE or RESP SHALL be ignored.
REQ-023 hold_flag_o SHALL equal m0_req_i AND NOT m0_ack_o (combinational).
REQ-024 Minimum latency SHALL be: req at cycle 0 -> s_req_o at cycle 1 -> (s_ack_i at cycle 1) -> mX_ack_o at cycle 2 -> IDLE at cycle 3.
REQ-025 The timeout counter SHALL clear on entry to BUSY and be wide enough for TIMEOUT with no wrap.

Reset
REQ-026 rst low SHALL immediately force: state IDLE, owner 0, starve_cnt 0, timeout counter 0, s_req_o 0, s_we_o 0, s_addr_o 0, s_wdata_o 0, s_wstrb_o 0, m0/m1_ack_o 0, m0/m1_rdata_o 0, err_o 0.
REQ-027 Reset asserted during BUSY SHALL abort the transfer with no ack to either master.
REQ-028 After rst deasserts, the first grant SHALL occur at the first rising edge with a req high.

Verification
REQ-029 Bench SHALL cover: m0 read 0x100, slave acks 2 cycles after s_req_o with 0xDEADBEEF -> m0_ack_o one cycle, m0_rdata_o=0xDEADBEEF, hold_flag_o low after ack.
REQ-030 Bench SHALL cover: m0 and m1 requesting simultaneously, m1 write 0x200/0x12345678/wstrb 4'hF -> m1 served first with s_we_o=1, then m0.
REQ-031 Bench SHALL cover: m0 held high and m1 re-requesting continuously, slave acks immediately -> exactly 4 m1 grants, then an m0 grant, then starve_cnt=0.
REQ-032 Bench SHALL cover: slave never acks -> s_req_o high for 15 cycles, then m_ack_o and err_o for one cycle with rdata=0, then IDLE.
REQ-033 Bench SHALL cover: s_ack_i in the 15th BUSY cycle -> normal ack, err_o=0.
REQ-034 Bench SHALL cover: rst pulsed low mid-BUSY -> all outputs 0 asynchronously, no ack, fresh grant after release.
